// File: rtl/types_pkg.sv
// Shared types for the store commit buffer: queue entry layout and load width codes.
package types_pkg;

   // Widest address an entry can hold; the top's ADDR_W must not exceed it.
   localparam int SB_ADDR_W = 32;

   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [31:0]          data;
      logic                 sh;
      logic [4:0]           rob_tag;
      logic                 valid;
   } sb_entry_t;

endpackage

// File: rtl/sb_overlap_chk.sv
// Byte-range overlap test between one queued store and a candidate load.
module sb_overlap_chk
   import types_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] st_addr,
   input  logic              st_sh,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [2:0]        ld_func3,
   output logic              hit
);

   // Two extra bits keep range ends from wrapping past the top of memory.
   localparam int RW = ADDR_W + 2;

   logic [RW-1:0] st_lo, st_hi, ld_lo, ld_hi;

   always_comb begin
      st_lo = RW'(st_addr);
      st_hi = st_lo + (st_sh ? RW'(1) : RW'(3));
      ld_lo = RW'(ld_addr);
      case (ld_func3)
         LBU:     ld_hi = ld_lo;
         LW:      ld_hi = ld_lo + RW'(3);
         default: ld_hi = ld_lo + RW'(3);
      endcase
      hit = (st_lo <= ld_hi) && (ld_lo <= st_hi);
   end

endmodule

// File: rtl/store_commit_buffer.sv
// In-order buffer of committed stores draining to data memory, with load overlap detection.
module store_commit_buffer
   import types_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enq_valid,
   output logic                        enq_ready,
   input  logic [ADDR_W-1:0]           enq_addr,
   input  logic [31:0]                 enq_data,
   input  logic                        enq_sh,
   input  logic [4:0]                  enq_rob_tag,
   input  logic                        mem_busy,
   output logic                        store_wb,
   output logic [ADDR_W-1:0]           wb_addr,
   output logic [31:0]                 wb_data,
   output logic                        wb_sh,
   output logic [4:0]                  wb_rob_tag,
   input  logic [ADDR_W-1:0]           ld_addr,
   input  logic [2:0]                  ld_func3,
   output logic                        ld_conflict,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        empty,
   output logic                        full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sb_entry_t        q [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic             do_enq, do_drain;
   logic [DEPTH-1:0] hit, valid_vec;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign enq_ready = !full;
   assign do_enq    = enq_valid && !full;
   assign do_drain  = !empty && !mem_busy;

   for (genvar i = 0; i < DEPTH; i++) begin : g_chk
      sb_overlap_chk #(.ADDR_W(ADDR_W)) u_chk (
         .st_addr  (ADDR_W'(q[i].addr)),
         .st_sh    (q[i].sh),
         .ld_addr  (ld_addr),
         .ld_func3 (ld_func3),
         .hit      (hit[i])
      );
      assign valid_vec[i] = q[i].valid;
   end

   assign ld_conflict = |(hit & valid_vec);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         store_wb   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         wb_sh      <= 1'b0;
         wb_rob_tag <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else begin
         store_wb <= do_drain;
         // head and tail only coincide when empty or full, so these never touch the same slot.
         if (do_drain) begin
            wb_addr       <= ADDR_W'(q[head].addr);
            wb_data       <= q[head].data;
            wb_sh         <= q[head].sh;
            wb_rob_tag    <= q[head].rob_tag;
            q[head].valid <= 1'b0;
            head          <= head + PTR_W'(1);
         end
         if (do_enq) begin
            q[tail] <= '{addr: SB_ADDR_W'(enq_addr), data: enq_data, sh: enq_sh,
                         rob_tag: enq_rob_tag, valid: 1'b1};
            tail    <= tail + PTR_W'(1);
         end
         case ({do_enq, do_drain})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for store_commit_buffer.
module tb_store_commit_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_addr;
   logic [31:0] enq_data;
   logic        enq_sh;
   logic [4:0]  enq_rob_tag;
   logic        mem_busy;
   logic        store_wb;
   logic [31:0] wb_addr;
   logic [31:0] wb_data;
   logic        wb_sh;
   logic [4:0]  wb_rob_tag;
   logic [31:0] ld_addr;
   logic [2:0]  ld_func3;
   logic        ld_conflict;
   logic [3:0]  count;
   logic        empty;
   logic        full;

   int total = 0;
   int bad   = 0;

   store_commit_buffer #(.DEPTH(8), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
      .enq_data(enq_data), .enq_sh(enq_sh), .enq_rob_tag(enq_rob_tag),
      .mem_busy(mem_busy), .store_wb(store_wb), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_sh(wb_sh), .wb_rob_tag(wb_rob_tag),
      .ld_addr(ld_addr), .ld_func3(ld_func3), .ld_conflict(ld_conflict),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic sh, input logic [4:0] tag);
      enq_valid   = 1'b1;
      enq_addr    = a;
      enq_data    = d;
      enq_sh      = sh;
      enq_rob_tag = tag;
      tick();
      enq_valid   = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] f3);
      ld_addr  = a;
      ld_func3 = f3;
      #1;
   endtask

   initial begin
      int pulses;
      reset = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_sh = 1'b0;
      enq_rob_tag = '0; mem_busy = 1'b0; ld_addr = '0; ld_func3 = 3'b100;
      tick(); tick();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ready", enq_ready, 1);
      chk("rst_count", count, 0);
      chk("rst_wb", store_wb, 0);
      chk("rst_wb_addr", wb_addr, 0);
      #2 reset = 1'b0;

      // single sw, drained the cycle after enqueue
      enq(32'h100, 32'hDEADBEEF, 1'b0, 5'd3);
      chk("t1_no_bypass", store_wb, 0);
      chk("t1_count1", count, 1);
      tick();
      chk("t1_wb", store_wb, 1);
      chk("t1_addr", wb_addr, 32'h100);
      chk("t1_data", wb_data, 32'hDEADBEEF);
      chk("t1_sh", wb_sh, 0);
      chk("t1_tag", wb_rob_tag, 3);
      chk("t1_count0", count, 0);
      tick();
      chk("t1_wb_off", store_wb, 0);

      // fill to full while memory is busy
      mem_busy = 1'b1;
      for (int i = 0; i < 8; i++) enq(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 5'(i));
      chk("t2_full", full, 1);
      chk("t2_ready", enq_ready, 0);
      chk("t2_count", count, 8);
      chk("t2_busy_wb", store_wb, 0);
      enq(32'h9999, 32'h99, 1'b0, 5'd31);
      chk("t2_drop_count", count, 8);
      chk("t2_hold_wb", store_wb, 0);
      // release memory with an enqueue attempt in the same cycle: still refused
      mem_busy = 1'b0; enq_valid = 1'b1; enq_addr = 32'h9999; enq_data = 32'h99; #1;
      chk("t2_ready_drain", enq_ready, 0);
      tick();
      enq_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         chk($sformatf("t2_wb%0d", i), store_wb, 1);
         chk($sformatf("t2_data%0d", i), wb_data, 32'hA0 + 32'(i));
         chk($sformatf("t2_tag%0d", i), wb_rob_tag, 5'(i));
         chk($sformatf("t2_cnt%0d", i), count, 4'(7 - i));
      end
      tick();
      chk("t2_end_wb", store_wb, 0);
      chk("t2_end_empty", empty, 1);

      // simultaneous enqueue and drain at count=4, across pointer wrap
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) enq(32'h2000 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 5'(i));
      chk("t3_count4", count, 4);
      mem_busy = 1'b0;
      for (int i = 4; i < 10; i++) begin
         enq(32'h2000 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 5'(i));
         chk($sformatf("t3_cnt%0d", i), count, 4);
         chk($sformatf("t3_data%0d", i), wb_data, 32'hB0 + 32'(i - 4));
         chk($sformatf("t3_wb%0d", i), store_wb, 1);
      end
      for (int i = 6; i < 10; i++) begin
         tick();
         chk($sformatf("t3_tail%0d", i), wb_data, 32'hB0 + 32'(i));
         chk($sformatf("t3_addr%0d", i), wb_addr, 32'h2000 + 32'(i * 4));
      end
      tick();
      chk("t3_empty", empty, 1);

      // overlap checks against a queued sh at 0x202
      mem_busy = 1'b1;
      enq(32'h202, 32'h1234, 1'b1, 5'd7);
      load(32'h203, 3'b100); chk("t4_lbu203", ld_conflict, 1);
      load(32'h204, 3'b100); chk("t4_lbu204", ld_conflict, 0);
      load(32'h200, 3'b010); chk("t4_lw200", ld_conflict, 1);
      load(32'h1FC, 3'b010); chk("t4_lw1fc", ld_conflict, 0);
      load(32'h1FF, 3'b000); chk("t4_other1ff", ld_conflict, 1);
      load(32'h201, 3'b100); chk("t4_lbu201", ld_conflict, 0);
      load(32'h203, 3'b100);
      mem_busy = 1'b0; #1;
      chk("t4_leaving_counts", ld_conflict, 1);
      tick();
      chk("t4_sh_wb", wb_sh, 1);
      chk("t4_drained", ld_conflict, 0);

      // top-of-memory store must not wrap onto address 0
      mem_busy = 1'b1;
      enq(32'hFFFFFFFE, 32'h55, 1'b0, 5'd9);
      load(32'h0, 3'b100); chk("t5_nowrap", ld_conflict, 0);
      load(32'hFFFFFFFF, 3'b100); chk("t5_top", ld_conflict, 1);

      // async reset with three entries pending
      enq(32'h300, 32'h66, 1'b0, 5'd10);
      enq(32'h304, 32'h77, 1'b0, 5'd11);
      chk("t6_count3", count, 3);
      #2 reset = 1'b1; #1;
      chk("t6_empty", empty, 1);
      chk("t6_wb", store_wb, 0);
      chk("t6_conflict", ld_conflict, 0);
      #2 reset = 1'b0;
      mem_busy = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (store_wb) pulses++;
      end
      chk("t6_no_pulses", pulses, 0);
      enq(32'h400, 32'h88, 1'b0, 5'd12);
      tick();
      chk("t6_new_wb", store_wb, 1);
      chk("t6_new_data", wb_data, 32'h88);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
